// File: rtl/alu_serial_driver.sv
// Bit-serial sequencer for a 1-bit ALU slice: feeds operands LSB first, chains the
// carry through a register and assembles result, zero and overflow at the MSB edge.
module alu_serial_driver #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic [5:0]       slice_sig,
    output logic             slice_less,
    input  logic             slice_out,
    input  logic             slice_cout
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, shadow;
    logic [WIDTH-1:0] fin;
    logic [5:0]       funct_q;
    logic [IW-1:0]    idx;
    logic             carry;
    logic             run, last;
    logic             start_neg_b;
    logic             op_slt, op_no_ovf;
    logic             less, ovf_nxt;

    assign run  = (state == S_RUN);
    assign last = run && (idx == IW'(WIDTH - 1));

    // SUB and SLT seed the carry with 1 to complete the two's complement of B.
    assign start_neg_b = (funct == F_SUB) || (funct == F_SLT);
    assign op_slt      = (funct_q == F_SLT);
    assign op_no_ovf   = (funct_q == F_AND) || (funct_q == F_OR) || op_slt;

    // Sign of A-B corrected for overflow; carry-in to the MSB cancels out.
    assign less    = a_q[WIDTH-1] ^ ~b_q[WIDTH-1] ^ slice_cout;
    assign ovf_nxt = op_no_ovf ? 1'b0 : (carry ^ slice_cout);

    always_comb begin
        fin            = shadow;
        fin[WIDTH-1]   = slice_out;
        if (op_slt) begin
            fin    = '0;
            fin[0] = less;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last)  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            funct_q  <= '0;
            shadow   <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && start) begin
                a_q     <= opA;
                b_q     <= opB;
                funct_q <= funct;
                shadow  <= '0;
                idx     <= '0;
                carry   <= start_neg_b;
            end else if (run) begin
                shadow[idx] <= slice_out;
                carry       <= slice_cout;
                idx         <= idx + 1'b1;
                if (last) begin
                    result   <= fin;
                    zero     <= (fin == '0);
                    overflow <= ovf_nxt;
                end
            end
        end
    end

    assign busy       = run;
    assign done       = (state == S_DONE);
    assign slice_a    = run ? a_q[idx] : 1'b0;
    assign slice_b    = run ? b_q[idx] : 1'b0;
    assign slice_cin  = run ? carry : 1'b0;
    assign slice_sig  = run ? funct_q : 6'h00;
    assign slice_less = 1'b0;

endmodule
